// File: rtl/phys_free_list.sv
// phys_free_list: circular FIFO of free physical register tags feeding rename and refilled by retire
module phys_free_list #(
   parameter int NUM_PREGS = 64,
   parameter int NUM_AREGS = 32,
   parameter int TAG_W     = 6
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [1:0]       i_alloc_req,
   output logic             o_alloc_gnt,
   output logic [TAG_W-1:0] o_alloc_tag0,
   output logic [TAG_W-1:0] o_alloc_tag1,
   input  logic [1:0]       i_rel_valid,
   input  logic [TAG_W-1:0] i_rel_tag0,
   input  logic [TAG_W-1:0] i_rel_tag1,
   output logic [5:0]       o_free_count,
   output logic             o_empty,
   output logic             o_full,
   output logic             o_overflow_err
);
   localparam int DEPTH = NUM_PREGS - NUM_AREGS;
   localparam int PTR_W = $clog2(DEPTH);

   logic [TAG_W-1:0] r_fifo [DEPTH];
   logic [PTR_W-1:0] r_head, r_tail;
   logic [5:0]       r_count;
   logic             r_err;

   logic [1:0]       w_n_req, w_n_pop, w_n_rel, w_n_acc;
   logic [5:0]       w_room;
   logic [TAG_W-1:0] w_push0;

   // grant, release acceptance and lane compaction
   always_comb begin
      w_n_req     = {1'b0, i_alloc_req[0]} + {1'b0, i_alloc_req[1]};
      w_n_rel     = {1'b0, i_rel_valid[0]} + {1'b0, i_rel_valid[1]};
      o_alloc_gnt = (w_n_req != 2'd0) && (r_count >= 6'(w_n_req));
      w_n_pop     = o_alloc_gnt ? w_n_req : 2'd0;
      w_room      = 6'(DEPTH) - r_count + 6'(w_n_pop);
      w_n_acc     = (6'(w_n_rel) > w_room) ? w_room[1:0] : w_n_rel;
      w_push0     = i_rel_valid[0] ? i_rel_tag0 : i_rel_tag1;
   end

   assign o_alloc_tag0   = r_fifo[r_head];
   assign o_alloc_tag1   = r_fifo[r_head + PTR_W'(1)];
   assign o_free_count   = r_count;
   assign o_empty        = (r_count == 6'd0);
   assign o_full         = (r_count == 6'(DEPTH));
   assign o_overflow_err = r_err;

   // pointer, count and storage update; reset refills with tags not mapped by the RAT
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= 6'(DEPTH);
         r_err   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_fifo[i] <= TAG_W'(NUM_AREGS + i);
      end else begin
         r_head  <= r_head + PTR_W'(w_n_pop);
         r_tail  <= r_tail + PTR_W'(w_n_acc);
         r_count <= r_count - 6'(w_n_pop) + 6'(w_n_acc);
         if (w_n_acc != w_n_rel) r_err <= 1'b1;
         if (w_n_acc != 2'd0) r_fifo[r_tail] <= w_push0;
         if (w_n_acc == 2'd2) r_fifo[r_tail + PTR_W'(1)] <= i_rel_tag1;
      end
   end
endmodule

// File: tb/tb_phys_free_list.sv
// tb_phys_free_list: directed scenario tests for the physical tag free list
module tb_phys_free_list;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] req, rel;
   logic [5:0] rt0, rt1;
   logic       gnt, empty, full, err;
   logic [5:0] tag0, tag1, cnt;
   int         n_tests = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   phys_free_list dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_alloc_req(req), .o_alloc_gnt(gnt),
      .o_alloc_tag0(tag0), .o_alloc_tag1(tag1), .i_rel_valid(rel),
      .i_rel_tag0(rt0), .i_rel_tag1(rt1), .o_free_count(cnt),
      .o_empty(empty), .o_full(full), .o_overflow_err(err)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      req = 2'b00; rel = 2'b00; rt0 = '0; rt1 = '0;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset;
      do_reset;
      n_tests++; if (cnt !== 6'd32) begin n_fail++; $display("FAIL reset_count: got %0d want 32", cnt); end
      n_tests++; if (full !== 1'b1 || empty !== 1'b0) begin n_fail++; $display("FAIL reset_flags: full=%0b empty=%0b want 1 0", full, empty); end
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", err); end
      n_tests++; if (tag0 !== 6'd32 || tag1 !== 6'd33) begin n_fail++; $display("FAIL reset_tags: got %0d %0d want 32 33", tag0, tag1); end
      n_tests++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL reset_nogrant: got %0b want 0", gnt); end
   endtask

   task automatic test_single_alloc;
      do_reset;
      req = 2'b01; #1;
      n_tests++; if (gnt !== 1'b1 || tag0 !== 6'd32) begin n_fail++; $display("FAIL single_grant: gnt=%0b tag0=%0d want 1 32", gnt, tag0); end
      tick; req = 2'b00; #1;
      n_tests++; if (tag0 !== 6'd33 || cnt !== 6'd31) begin n_fail++; $display("FAIL single_next: tag0=%0d cnt=%0d want 33 31", tag0, cnt); end
   endtask

   task automatic test_dual_alloc;
      do_reset;
      req = 2'b11; #1;
      n_tests++; if (gnt !== 1'b1 || tag0 !== 6'd32 || tag1 !== 6'd33) begin n_fail++; $display("FAIL dual_first: gnt=%0b tags=%0d %0d want 1 32 33", gnt, tag0, tag1); end
      tick;
      n_tests++; if (gnt !== 1'b1 || tag0 !== 6'd34 || tag1 !== 6'd35) begin n_fail++; $display("FAIL dual_second: gnt=%0b tags=%0d %0d want 1 34 35", gnt, tag0, tag1); end
      tick; req = 2'b00; #1;
      n_tests++; if (cnt !== 6'd28) begin n_fail++; $display("FAIL dual_count: got %0d want 28", cnt); end
   endtask

   task automatic test_drain;
      do_reset;
      req = 2'b11;
      for (int i = 0; i < 15; i++) tick;
      req = 2'b01; tick;
      req = 2'b11; #1;
      n_tests++; if (cnt !== 6'd1 || gnt !== 1'b0) begin n_fail++; $display("FAIL drain_deny: cnt=%0d gnt=%0b want 1 0", cnt, gnt); end
      tick;
      n_tests++; if (cnt !== 6'd1) begin n_fail++; $display("FAIL drain_hold: cnt=%0d want 1", cnt); end
      req = 2'b10; #1;
      n_tests++; if (gnt !== 1'b1 || tag0 !== 6'd63) begin n_fail++; $display("FAIL drain_last: gnt=%0b tag0=%0d want 1 63", gnt, tag0); end
      tick; req = 2'b00; #1;
      n_tests++; if (empty !== 1'b1 || cnt !== 6'd0) begin n_fail++; $display("FAIL drain_empty: empty=%0b cnt=%0d want 1 0", empty, cnt); end
   endtask

   task automatic test_empty_release;
      rel = 2'b01; rt0 = 6'd5; req = 2'b01; #1;
      n_tests++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL nobypass_gnt: got %0b want 0", gnt); end
      tick; rel = 2'b00; #1;
      n_tests++; if (gnt !== 1'b1 || tag0 !== 6'd5) begin n_fail++; $display("FAIL nobypass_next: gnt=%0b tag0=%0d want 1 5", gnt, tag0); end
      tick; req = 2'b00; #1;
      n_tests++; if (cnt !== 6'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL nobypass_count: cnt=%0d empty=%0b want 0 1", cnt, empty); end
   endtask

   task automatic test_wrap;
      int e0, e1;
      do_reset;
      req = 2'b11;
      for (int i = 0; i < 10; i++) tick;
      req = 2'b00;
      for (int k = 0; k < 10; k++) begin
         rel = 2'b11; rt0 = 6'(40 + 2 * k); rt1 = 6'(41 + 2 * k); tick;
      end
      rel = 2'b00; #1;
      n_tests++; if (cnt !== 6'd32 || full !== 1'b1) begin n_fail++; $display("FAIL wrap_full: cnt=%0d full=%0b want 32 1", cnt, full); end
      for (int p = 0; p < 16; p++) begin
         e0 = (2 * p < 12) ? 52 + 2 * p : 40 + 2 * p - 12;
         e1 = (2 * p + 1 < 12) ? 53 + 2 * p : 41 + 2 * p - 12;
         req = 2'b11; #1;
         n_tests++; if (gnt !== 1'b1 || tag0 !== 6'(e0) || tag1 !== 6'(e1)) begin n_fail++; $display("FAIL wrap_pop%0d: gnt=%0b tags=%0d %0d want 1 %0d %0d", p, gnt, tag0, tag1, e0, e1); end
         tick;
      end
      req = 2'b00; #1;
      n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %0b want 1", empty); end
   endtask

   task automatic test_back_to_back;
      do_reset;
      req = 2'b11; rel = 2'b11; rt0 = 6'd10; rt1 = 6'd11; #1;
      n_tests++; if (gnt !== 1'b1 || tag0 !== 6'd32 || tag1 !== 6'd33) begin n_fail++; $display("FAIL b2b_grant: gnt=%0b tags=%0d %0d want 1 32 33", gnt, tag0, tag1); end
      tick; req = 2'b00; rel = 2'b00; #1;
      n_tests++; if (cnt !== 6'd32 || err !== 1'b0) begin n_fail++; $display("FAIL b2b_count: cnt=%0d err=%0b want 32 0", cnt, err); end
   endtask

   task automatic test_overflow;
      do_reset;
      rel = 2'b11; rt0 = 6'd7; rt1 = 6'd8; tick;
      rel = 2'b00; #1;
      n_tests++; if (cnt !== 6'd32 || err !== 1'b1) begin n_fail++; $display("FAIL ovf_drop: cnt=%0d err=%0b want 32 1", cnt, err); end
      n_tests++; if (tag0 !== 6'd32) begin n_fail++; $display("FAIL ovf_head: got %0d want 32", tag0); end
      tick;
      n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b want 1", err); end
      rel = 2'b11; req = 2'b01; #1;
      n_tests++; if (gnt !== 1'b1 || tag0 !== 6'd32) begin n_fail++; $display("FAIL ovf_pop: gnt=%0b tag0=%0d want 1 32", gnt, tag0); end
      tick; rel = 2'b00; req = 2'b00; #1;
      n_tests++; if (cnt !== 6'd32) begin n_fail++; $display("FAIL ovf_partial: cnt=%0d want 32", cnt); end
      req = 2'b11;
      for (int i = 0; i < 15; i++) tick;
      req = 2'b01; #1;
      n_tests++; if (tag0 !== 6'd63) begin n_fail++; $display("FAIL ovf_tail63: got %0d want 63", tag0); end
      tick;
      n_tests++; if (gnt !== 1'b1 || tag0 !== 6'd7) begin n_fail++; $display("FAIL ovf_kept7: gnt=%0b tag0=%0d want 1 7", gnt, tag0); end
      tick; req = 2'b00; #1;
      n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty: got %0b want 1", empty); end
      rel = 2'b10; rt0 = 6'd3; rt1 = 6'd9; tick;
      rel = 2'b00; req = 2'b10; #1;
      n_tests++; if (gnt !== 1'b1 || tag0 !== 6'd9 || cnt !== 6'd1) begin n_fail++; $display("FAIL compact: gnt=%0b tag0=%0d cnt=%0d want 1 9 1", gnt, tag0, cnt); end
      rst_n = 1'b0; #1;
      n_tests++; if (cnt !== 6'd32 || err !== 1'b0 || tag0 !== 6'd32 || full !== 1'b1) begin n_fail++; $display("FAIL midreset: cnt=%0d err=%0b tag0=%0d full=%0b want 32 0 32 1", cnt, err, tag0, full); end
      req = 2'b00; #1;
      rst_n = 1'b1;
      tick;
      n_tests++; if (cnt !== 6'd32 || tag0 !== 6'd32) begin n_fail++; $display("FAIL postreset: cnt=%0d tag0=%0d want 32 32", cnt, tag0); end
   endtask

   initial begin
      test_reset;
      test_single_alloc;
      test_dual_alloc;
      test_drain;
      test_empty_release;
      test_wrap;
      test_back_to_back;
      test_overflow;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within 200000 time units");
      $fatal(1);
   end
endmodule
